// File: rtl/request_encoder_8_to_3_pkg.sv
// encoder_pkg: shared sizes and types for the request encoder slice.
//   N        number of request lines (8 in this revision)
//   IDX_W    index width, $clog2(N)
//   enc_state_t  offer FSM state
//   enc_idx_t    binary source index
package encoder_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {ENC_IDLE, ENC_OFFER} enc_state_t;

    typedef logic [IDX_W-1:0] enc_idx_t;

endpackage : encoder_pkg

// File: rtl/request_encoder_8_to_3_if.sv
// request_encoder_8_to_3_if: request capture and index handshake bundle.
//   ena      capture enable (producer -> encoder)
//   req      request lines (producer -> encoder)
//   ready    consumer accepts out this cycle (consumer -> encoder)
//   out      offered index (encoder -> consumer)
//   valid    an index is being offered (encoder -> consumer)
//   pending  sticky pending vector (encoder -> observers)
// modport slave is the encoder's view, master the environment's view.
interface request_encoder_8_to_3_if;
    import encoder_pkg::*;

    logic         ena;
    logic [N-1:0] req;
    logic         ready;
    enc_idx_t     out;
    logic         valid;
    logic [N-1:0] pending;

    modport master (
        output ena, req, ready,
        input  out, valid, pending
    );

    modport slave (
        input  ena, req, ready,
        output out, valid, pending
    );

endinterface : request_encoder_8_to_3_if

// File: rtl/request_encoder_8_to_3_priority_encoder.sv
// priority_encoder_8_to_3: combinational fixed-priority encoder, bit 0 wins.
//   vec  input  8  candidate vector
//   idx  output 3  index of the lowest set bit (0 when none set)
//   any  output 1  at least one bit of vec is set
module priority_encoder_8_to_3
    import encoder_pkg::*;
(
    input  logic [N-1:0] vec,
    output enc_idx_t     idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i] && !any) begin
                idx = enc_idx_t'(i);
                any = 1'b1;
            end
        end
    end

endmodule : priority_encoder_8_to_3

// File: rtl/request_encoder_8_to_3.sv
// request_encoder_8_to_3: latches 8 request lines into a sticky pending
// vector and hands their indices out one at a time over valid/ready,
// round-robin from a rotating pointer so no source starves.
//   clk  input   system clock, rising edge
//   rst  input   asynchronous active-low reset
//   bus  slave   ena/req/ready in, out/valid/pending out (all registered)
module request_encoder_8_to_3
    import encoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    request_encoder_8_to_3_if.slave bus
);

    enc_state_t   state_q;
    enc_idx_t     ptr_q;
    enc_idx_t     out_q;
    logic         valid_q;
    logic [N-1:0] pending_q;

    logic         accept;
    logic [N-1:0] clr;
    logic [N-1:0] cand;
    enc_idx_t     base;
    logic [N-1:0] rot;
    enc_idx_t     pe_idx;
    logic         pe_any;
    enc_idx_t     sel;

    assign accept = valid_q && bus.ready;

    // On an accept the search starts just past the accepted index, i.e.
    // from the pointer value being written this edge, so back-to-back
    // offers already follow the updated round-robin order.
    always_comb begin
        clr  = '0;
        base = ptr_q;
        if (accept) begin
            clr[out_q] = 1'b1;
            base       = enc_idx_t'(out_q + 1'b1);
        end
        cand = pending_q & ~clr;
    end

    // Rotate right by base so the search start lands on bit 0; the
    // index arithmetic wraps naturally in IDX_W bits.
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rot[i] = cand[enc_idx_t'(i) + base];
        end
    end

    priority_encoder_8_to_3 u_prio (
        .vec (rot),
        .idx (pe_idx),
        .any (pe_any)
    );

    assign sel = enc_idx_t'(pe_idx + base);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ENC_IDLE;
            ptr_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            // Set wins over clear: a fresh req on the accepted bit re-pends it.
            pending_q <= cand | (bus.ena ? bus.req : '0);
            if (accept) begin
                ptr_q <= base;
            end
            case (state_q)
                ENC_IDLE: begin
                    if (pe_any) begin
                        out_q   <= sel;
                        valid_q <= 1'b1;
                        state_q <= ENC_OFFER;
                    end
                end
                ENC_OFFER: begin
                    if (accept) begin
                        if (pe_any) begin
                            out_q <= sel;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= ENC_IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ENC_IDLE;
                end
            endcase
        end
    end

    assign bus.out     = out_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;

endmodule : request_encoder_8_to_3

// File: tb/tb_request_encoder_8_to_3.sv
module tb_request_encoder_8_to_3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    request_encoder_8_to_3_if bus ();

    request_encoder_8_to_3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue-free but purely arithmetic view of the rules.
    logic [7:0] m_pending;
    int         m_ptr;
    int         m_out;
    logic       m_valid;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 8'h00;
        m_ptr     = 0;
        m_out     = 0;
        m_valid   = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, {7'd0, bus.valid}, {7'd0, m_valid});
        check({tag, ".pending"}, bus.pending, m_pending);
        check({tag, ".out"}, {5'd0, bus.out}, 8'(m_out));
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic cycle(input logic ena, input logic [7:0] req, input logic ready, input string tag);
        logic       accept;
        int         start;
        int         found;
        logic [7:0] remaining;
        bus.ena   = ena;
        bus.req   = req;
        bus.ready = ready;
        accept    = m_valid && ready;
        remaining = m_pending;
        start     = m_ptr;
        if (accept) begin
            remaining[m_out] = 1'b0;
            start = (m_out + 1) % 8;
        end
        found = -1;
        for (int k = 0; k < 8; k++) begin
            if (found < 0 && remaining[(start + k) % 8]) found = (start + k) % 8;
        end
        @(posedge clk);
        #1;
        if (!m_valid || accept) begin
            if (found >= 0) begin
                m_out   = found;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (accept) m_ptr = start;
        m_pending = remaining | (ena ? req : 8'h00);
        check_model(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.ena   = 1'b0;
        bus.req   = 8'h00;
        bus.ready = 1'b0;
        model_reset();

        // Reset / idle
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_model("reset");
        end
        rst = 1'b1;
        repeat (2) cycle(1'b1, 8'h00, 1'b1, "idle");
        check("idle_out", {5'd0, bus.out}, 8'd0);

        // Single request: offered two edges later for exactly one cycle
        cycle(1'b1, 8'h20, 1'b1, "single_cap");
        check("single_cap_valid", {7'd0, bus.valid}, 8'd0);
        cycle(1'b1, 8'h00, 1'b1, "single_offer");
        check("single_valid", {7'd0, bus.valid}, 8'd1);
        check("single_out", {5'd0, bus.out}, 8'd5);
        cycle(1'b1, 8'h00, 1'b1, "single_done");
        check("single_drop", {7'd0, bus.valid}, 8'd0);
        check("single_pend", bus.pending, 8'h00);

        // Round-robin wrap from ptr=6 over bits 0,1,6
        cycle(1'b1, 8'h43, 1'b1, "wrap_cap");
        cycle(1'b1, 8'h00, 1'b1, "wrap_a");
        check("wrap_out6", {5'd0, bus.out}, 8'd6);
        cycle(1'b1, 8'h00, 1'b1, "wrap_b");
        check("wrap_out0", {5'd0, bus.out}, 8'd0);
        cycle(1'b1, 8'h00, 1'b1, "wrap_c");
        check("wrap_out1", {5'd0, bus.out}, 8'd1);
        cycle(1'b1, 8'h00, 1'b1, "wrap_d");
        check("wrap_idle", {7'd0, bus.valid}, 8'd0);

        // Backpressure
        cycle(1'b1, 8'h0C, 1'b0, "bp_cap");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'h00, 1'b0, "bp_hold");
            check("bp_out2", {5'd0, bus.out}, 8'd2);
            check("bp_pend", bus.pending, 8'h0C);
        end
        cycle(1'b1, 8'h00, 1'b1, "bp_rel_a");
        check("bp_out3", {5'd0, bus.out}, 8'd3);
        cycle(1'b1, 8'h00, 1'b1, "bp_rel_b");
        check("bp_idle", {7'd0, bus.valid}, 8'd0);

        // Set wins over clear on the accepted bit
        cycle(1'b1, 8'h2A, 1'b0, "sw_cap");
        cycle(1'b1, 8'h00, 1'b1, "sw_a");
        check("sw_out5", {5'd0, bus.out}, 8'd5);
        cycle(1'b1, 8'h00, 1'b1, "sw_b");
        check("sw_out1", {5'd0, bus.out}, 8'd1);
        cycle(1'b1, 8'h00, 1'b1, "sw_c");
        check("sw_out3", {5'd0, bus.out}, 8'd3);
        cycle(1'b1, 8'h0A, 1'b1, "sw_collide");
        check("sw_bit3", {7'd0, bus.pending[3]}, 8'd1);
        cycle(1'b1, 8'h00, 1'b1, "sw_e");
        check("sw_out1_again", {5'd0, bus.out}, 8'd1);
        cycle(1'b1, 8'h00, 1'b1, "sw_f");
        check("sw_out3_again", {5'd0, bus.out}, 8'd3);
        cycle(1'b1, 8'h00, 1'b1, "sw_g");

        // ena gating
        repeat (3) cycle(1'b0, 8'hFF, 1'b1, "gate");
        check("gate_pend", bus.pending, 8'h00);
        check("gate_valid", {7'd0, bus.valid}, 8'd0);

        // Fill all ones, then async reset mid-offer
        cycle(1'b1, 8'hFF, 1'b0, "fill");
        cycle(1'b1, 8'h00, 1'b0, "fill_offer");
        check("fill_valid", {7'd0, bus.valid}, 8'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("areset_valid", {7'd0, bus.valid}, 8'd0);
        check("areset_pend", bus.pending, 8'h00);
        check("areset_out", {5'd0, bus.out}, 8'd0);
        #1 rst = 1'b1;

        // All ones drain in pointer order
        cycle(1'b1, 8'hFF, 1'b1, "all_cap");
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'h00, 1'b1, "all_drain");
        check("all_idle", {7'd0, bus.valid}, 8'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cycle(($urandom_range(0, 7) != 0), r, ($urandom_range(0, 2) != 0), "rand");
        end
        repeat (12) cycle(1'b1, 8'h00, 1'b1, "rand_drain");
        check("rand_end_valid", {7'd0, bus.valid}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_request_encoder_8_to_3
